// File: rtl/counter_cmd_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : counter_cmd_seq_if
// Purpose  : Command valid/ready bus into the counter command sequencer.
// Revision : 1.0
// ============================================================================
interface counter_cmd_seq_if #(
   parameter int DATA_W = 8
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [DATA_W-1:0] cmd_data;

   modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface
`default_nettype wire

// File: rtl/counter_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : counter_cmd_seq
// Purpose  : Buffers LOAD / INC-by-N / NOP commands and replays them as
//            registered ld / inc / data_in strobes for the 8-bit counter.
//            Optional exp_q shadow output: define COUNTER_CMD_SEQ_SHADOW_EN.
// Revision : 1.0
// ============================================================================
module counter_cmd_seq #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   counter_cmd_seq_if.slave            cmd,
   output logic [DATA_W-1:0]           data_in,
   output logic                        ld,
   output logic                        inc,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
`ifdef COUNTER_CMD_SEQ_SHADOW_EN
   ,
   output logic [DATA_W-1:0]           exp_q
`endif
);

   localparam int            c_aw      = $clog2(FIFO_DEPTH);
   localparam logic [c_aw:0] c_depth   = FIFO_DEPTH[c_aw:0];
   localparam logic [1:0]    c_op_load = 2'b01;
   localparam logic [1:0]    c_op_inc  = 2'b10;

   typedef struct packed {
      logic [1:0]        op;
      logic [DATA_W-1:0] data;
   } cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_STROBE  = 2'd1,
      ST_INC_RUN = 2'd2
   } state_t;

   cmd_t              r_mem [FIFO_DEPTH];
   logic [c_aw-1:0]   r_wr_ptr;
   logic [c_aw-1:0]   r_rd_ptr;
   logic [c_aw:0]     r_count;
   logic              r_rdy_en;
   state_t            r_state;
   logic [DATA_W-1:0] r_remaining;

   logic              w_push;
   logic              w_pop;
   logic              w_dispatch;
   cmd_t              w_head;

   // Ready comes from registered occupancy only: a full FIFO never accepts,
   // even in a cycle that pops. r_rdy_en holds it low until the first edge
   // after reset release.
   assign cmd.cmd_ready = r_rdy_en && (r_count < c_depth);
   assign w_push        = cmd.cmd_valid && cmd.cmd_ready;
   assign w_head        = r_mem[r_rd_ptr];

   // Every state except a still-counting INC_RUN is a point where the next
   // command may be taken, which keeps back-to-back strobes gapless.
   assign w_dispatch    = (r_state != ST_INC_RUN) || (r_remaining == '0);
   assign w_pop         = w_dispatch && (r_count != '0);

   assign fifo_count    = r_count;
   assign busy          = (r_count != '0) || ld || inc || (r_state != ST_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_rdy_en <= 1'b0;
      end else begin
         r_rdy_en <= 1'b1;
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)
            r_count <= r_count + 1'b1;
         else if (w_pop && !w_push)
            r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {cmd.cmd_op, cmd.cmd_data};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_remaining <= '0;
         ld          <= 1'b0;
         inc         <= 1'b0;
         data_in     <= '0;
      end else if (!w_dispatch) begin
         r_remaining <= r_remaining - 1'b1;
      end else if (w_pop) begin
         ld      <= 1'b0;
         inc     <= 1'b0;
         r_state <= ST_STROBE;
         if (w_head.op == c_op_load) begin
            data_in <= w_head.data;
            ld      <= 1'b1;
         end else if ((w_head.op == c_op_inc) && (w_head.data != '0)) begin
            inc         <= 1'b1;
            r_remaining <= w_head.data - 1'b1;
            r_state     <= ST_INC_RUN;
         end
      end else begin
         r_state <= ST_IDLE;
         ld      <= 1'b0;
         inc     <= 1'b0;
      end
   end

`ifdef COUNTER_CMD_SEQ_SHADOW_EN
   // Mirrors the counter: follows each strobe one edge later.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         exp_q <= '0;
      else if (ld)
         exp_q <= data_in;
      else if (inc)
         exp_q <= exp_q + 1'b1;
   end
`endif

endmodule
`default_nettype wire
